// File: rtl/ram_dual_fifo_ctrl_if.sv
// Valid/ready word stream used on both the producer and consumer side of the FIFO controller.
// The master drives data/valid, the slave drives ready.
interface ram_dual_fifo_ctrl_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ram_dual_fifo_ctrl.sv
// Single-clock FIFO controller around an external registered-read dual-port RAM.
// A 2-entry head/skid buffer hides the 1-cycle RAM read latency so both sides sustain 1 word/cycle.
module ram_dual_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic                 clock,
    input  logic                 reset_n,
    ram_dual_fifo_ctrl_if.slave  in_stream,
    ram_dual_fifo_ctrl_if.master out_stream,
    output logic [DATA_W-1:0]    ram_data,
    output logic [ADDR_W-1:0]    ram_write_addr,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_read_addr,
    input  logic [DATA_W-1:0]    ram_q,
    output logic [ADDR_W+1:0]    count,
    output logic                 full,
    output logic                 empty
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int MEM_W = ADDR_W + 1;
    localparam int CNT_W = ADDR_W + 2;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [MEM_W-1:0]  mem_cnt;
    logic              pending;
    logic [1:0]        buf_cnt;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] skid;

    logic              in_ready;
    logic              out_valid;
    logic              push;
    logic              pop;
    logic              issue;
    logic [1:0]        buf_after_pop;
    logic [2:0]        occ_after_pop;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        buf_after_pop = buf_cnt;
        occ_after_pop = 3'd0;
        issue         = 1'b0;

        full          = (mem_cnt == MEM_W'(DEPTH));
        in_ready      = reset_n & ~full;
        out_valid     = (buf_cnt != 2'd0);
        push          = in_stream.valid & in_ready;
        pop           = out_valid & out_stream.ready;
        buf_after_pop = buf_cnt - {1'b0, pop};
        // A read may only be issued when its data has a guaranteed landing slot next cycle.
        occ_after_pop = {1'b0, buf_cnt} + {2'b00, pending} - {2'b00, pop};
        issue         = (mem_cnt != '0) && (occ_after_pop < 3'd2);
    end

    assign in_stream.ready  = in_ready;
    assign out_stream.valid = out_valid;
    assign out_stream.data  = head;

    // NOTE: the RAM array itself is never cleared; resetting pointers and counts is what keeps
    // stale words from ever being presented.
    assign ram_data       = in_stream.data;
    assign ram_write_addr = wr_ptr;
    assign ram_we         = push;
    assign ram_read_addr  = rd_ptr;

    assign count = CNT_W'(mem_cnt) + CNT_W'(pending) + CNT_W'(buf_cnt);
    assign empty = (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            pending <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            pending <= issue;
            case ({push, issue})
                2'b10:   mem_cnt <= mem_cnt + MEM_W'(1);
                2'b01:   mem_cnt <= mem_cnt - MEM_W'(1);
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

    // Output buffer: skid advances to head on pop; returning RAM data fills the first free slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            skid    <= '0;
            buf_cnt <= 2'd0;
        end else begin
            buf_cnt <= buf_after_pop + {1'b0, pending};
            if (pop && (buf_cnt == 2'd2)) begin
                head <= skid;
            end
            if (pending) begin
                if (buf_after_pop == 2'd0) begin
                    head <= ram_q;
                end else begin
                    skid <= ram_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_dual_fifo_ctrl.sv
// Directed bench for ram_dual_fifo_ctrl with a behavioural registered-read RAM and an ideal
// FIFO queue as reference for every word handed to the consumer.
module tb_ram_dual_fifo_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_write_addr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_read_addr;
    logic [DATA_W-1:0] ram_q;
    logic [ADDR_W+1:0] count;
    logic              full;
    logic              empty;

    ram_dual_fifo_ctrl_if #(.DATA_W(DATA_W)) in_stream ();
    ram_dual_fifo_ctrl_if #(.DATA_W(DATA_W)) out_stream ();

    ram_dual_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_stream      (in_stream),
        .out_stream     (out_stream),
        .ram_data       (ram_data),
        .ram_write_addr (ram_write_addr),
        .ram_we         (ram_we),
        .ram_read_addr  (ram_read_addr),
        .ram_q          (ram_q),
        .count          (count),
        .full           (full),
        .empty          (empty)
    );

    always #5 clock = ~clock;

    logic [DATA_W-1:0] ram_mem [64];
    always @(posedge clock) begin
        if (ram_we) ram_mem[ram_write_addr] <= ram_data;
        ram_q <= ram_mem[ram_read_addr];
    end

    int                tests = 0;
    int                fails = 0;
    logic [DATA_W-1:0] exp_q [$];

    logic              pushed, popped;
    logic [DATA_W-1:0] pop_data;
    logic              pre_valid, pre_we;
    logic [DATA_W-1:0] pre_data;
    logic [ADDR_W-1:0] pre_ra, pre_wa;

    // One clock cycle: drive at negedge, decide handshakes 1ns later, return at the next negedge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r);
        logic [DATA_W-1:0] exp;
        in_stream.valid  = v;
        in_stream.data   = d;
        out_stream.ready = r;
        #1;
        pushed    = v && in_stream.ready;
        popped    = out_stream.valid && r;
        pop_data  = out_stream.data;
        pre_valid = out_stream.valid;
        pre_data  = out_stream.data;
        pre_we    = ram_we;
        pre_ra    = ram_read_addr;
        pre_wa    = ram_write_addr;
        if (popped) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_order: got %h, model queue empty", out_stream.data);
            end else begin
                exp = exp_q.pop_front();
                if (out_stream.data !== exp) begin
                    fails++;
                    $display("FAIL pop_order: got %h want %h", out_stream.data, exp);
                end
            end
        end
        if (pushed) exp_q.push_back(d);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        in_stream.valid  = 1'b0;
        in_stream.data   = '0;
        out_stream.ready = 1'b0;
        #2;
        tests++; if (out_stream.valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_stream.valid); end
        tests++; if (out_stream.data !== 8'h00) begin fails++; $display("FAIL rst_out_data: got %h want 00", out_stream.data); end
        tests++; if (count !== 8'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty: got %b want 1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL rst_full: got %b want 0", full); end
        tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
        tests++; if (ram_write_addr !== 6'd0) begin fails++; $display("FAIL rst_wr_addr: got %0d want 0", ram_write_addr); end
        tests++; if (ram_read_addr !== 6'd0) begin fails++; $display("FAIL rst_rd_addr: got %0d want 0", ram_read_addr); end
        tests++; if (in_stream.ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", in_stream.ready); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        tests++; if (in_stream.ready !== 1'b1) begin fails++; $display("FAIL post_rst_in_ready: got %b want 1", in_stream.ready); end
    endtask

    task automatic test_single();
        step(1'b1, 8'hA5, 1'b1);
        tests++; if (pushed !== 1'b1) begin fails++; $display("FAIL single_push: got %b want 1", pushed); end
        tests++; if (ram_write_addr !== 6'd1) begin fails++; $display("FAIL single_wr_ptr: got %0d want 1", ram_write_addr); end
        tests++; if (out_stream.valid !== 1'b0) begin fails++; $display("FAIL single_valid_e0: got %b want 0", out_stream.valid); end
        tests++; if (count !== 8'd1) begin fails++; $display("FAIL single_count_e0: got %0d want 1", count); end
        step(1'b0, 8'h00, 1'b1);
        tests++; if (out_stream.valid !== 1'b0) begin fails++; $display("FAIL single_valid_e1: got %b want 0", out_stream.valid); end
        tests++; if (count !== 8'd1) begin fails++; $display("FAIL single_count_e1: got %0d want 1", count); end
        step(1'b0, 8'h00, 1'b1);
        tests++; if (out_stream.valid !== 1'b1) begin fails++; $display("FAIL single_valid_e2: got %b want 1", out_stream.valid); end
        tests++; if (out_stream.data !== 8'hA5) begin fails++; $display("FAIL single_data: got %h want a5", out_stream.data); end
        tests++; if (count !== 8'd1) begin fails++; $display("FAIL single_count_e2: got %0d want 1", count); end
        step(1'b0, 8'h00, 1'b1);
        tests++; if (popped !== 1'b1) begin fails++; $display("FAIL single_pop: got %b want 1", popped); end
        tests++; if (out_stream.valid !== 1'b0) begin fails++; $display("FAIL single_valid_after: got %b want 0", out_stream.valid); end
        tests++; if (count !== 8'd0) begin fails++; $display("FAIL single_count_after: got %0d want 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL single_empty_after: got %b want 1", empty); end
    endtask

    task automatic test_stream();
        int sent = 0, pops = 0, first = -1, last = -1, stalls = 0;
        for (int s = 0; s < 200 && pops < 64; s++) begin
            step(sent < 64, 8'(sent), 1'b1);
            if (sent < 64 && !pushed) stalls++;
            if (pushed) sent++;
            if (popped) begin
                if (first < 0) first = s;
                last = s;
                pops++;
            end
        end
        tests++; if (pops !== 64) begin fails++; $display("FAIL stream_pops: got %0d want 64", pops); end
        tests++; if (stalls !== 0) begin fails++; $display("FAIL stream_in_ready: got %0d stalls want 0", stalls); end
        tests++; if (first !== 3) begin fails++; $display("FAIL stream_first_pop: got cycle %0d want 3", first); end
        tests++; if (last !== 66) begin fails++; $display("FAIL stream_last_pop: got cycle %0d want 66", last); end
    endtask

    task automatic fill_66(input logic [DATA_W-1:0] base);
        int acc = 0;
        for (int s = 0; s < 100 && acc < 66; s++) begin
            step(1'b1, base + 8'(acc), 1'b0);
            if (pushed) acc++;
        end
        tests++; if (acc !== 66) begin fails++; $display("FAIL fill_accepts: got %0d want 66", acc); end
    endtask

    task automatic drain_all(input string name);
        for (int s = 0; s < 200 && exp_q.size() != 0; s++) step(1'b0, 8'h00, 1'b1);
        tests++; if (count !== 8'd0) begin fails++; $display("FAIL %s_drain_count: got %0d want 0", name, count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL %s_drain_empty: got %b want 1", name, empty); end
    endtask

    task automatic test_fill_drain();
        fill_66(8'h80);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 8'hC2, 1'b0);
            tests++; if (pushed !== 1'b0) begin fails++; $display("FAIL full_67th_accepted: got %b want 0", pushed); end
        end
        tests++; if (in_stream.ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b want 0", in_stream.ready); end
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL full_flag: got %b want 1", full); end
        tests++; if (count !== 8'd66) begin fails++; $display("FAIL full_count: got %0d want 66", count); end
        tests++; if (out_stream.data !== 8'h80) begin fails++; $display("FAIL full_head: got %h want 80", out_stream.data); end
        drain_all("fill");
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL fill_drain_full: got %b want 0", full); end
    endtask

    task automatic test_full_sustain();
        int pushes = 0;
        fill_66(8'h40);
        for (int i = 0; i < 120; i++) begin
            step(1'b1, 8'hD0 + 8'(i), 1'b1);
            if (pushed) pushes++;
            tests++;
            if (count < 8'd65 || count > 8'd66) begin
                fails++;
                $display("FAIL sustain_count: got %0d want 65..66", count);
            end
        end
        tests++; if (pushes !== 119) begin fails++; $display("FAIL sustain_pushes: got %0d want 119", pushes); end
        drain_all("sustain");
    endtask

    task automatic test_random();
        int sent = 0, recv = 0;
        logic hold;
        for (int s = 0; s < 20000 && recv < 2000; s++) begin
            logic v, r;
            v = (sent < 2000) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 1) == 1);
            step(v, 8'($urandom), r);
            hold = pre_valid && !r;
            if (pushed) sent++;
            if (popped) recv++;
            if (hold) begin
                tests++;
                if (out_stream.valid !== 1'b1 || out_stream.data !== pre_data) begin
                    fails++;
                    $display("FAIL rand_hold: got valid %b data %h want valid 1 data %h",
                             out_stream.valid, out_stream.data, pre_data);
                end
            end
            if (pre_we && ram_read_addr !== pre_ra) begin
                tests++;
                if (pre_ra === pre_wa) begin
                    fails++;
                    $display("FAIL rand_collision: read addr %0d equals write addr %0d", pre_ra, pre_wa);
                end
            end
        end
        tests++; if (recv !== 2000) begin fails++; $display("FAIL rand_received: got %0d want 2000", recv); end
        tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL rand_leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        logic seen = 1'b0;
        for (int s = 0; s < 30 && acc < 10; s++) begin
            step(1'b1, 8'h10 + 8'(acc), 1'b0);
            if (pushed) acc++;
        end
        for (int s = 0; s < 3; s++) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        tests++; if (out_stream.valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", out_stream.valid); end
        tests++; if (count !== 8'd0) begin fails++; $display("FAIL midrst_count: got %0d want 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL midrst_empty: got %b want 1", empty); end
        exp_q.delete();
        out_stream.ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 8'h3C, 1'b1);
        for (int s = 0; s < 10 && !seen; s++) begin
            step(1'b0, 8'h00, 1'b1);
            if (popped) begin
                seen = 1'b1;
                tests++;
                if (pop_data !== 8'h3C) begin fails++; $display("FAIL midrst_first_word: got %h want 3c", pop_data); end
            end
        end
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL midrst_no_output: got no word want 3c"); end
        tests++; if (count !== 8'd0) begin fails++; $display("FAIL midrst_final_count: got %0d want 0", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_fill_drain();
        test_full_sustain();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
